// File: rtl/data_mem_pkg.sv
// Package: data_mem_pkg
// Shared definitions for the data-memory port: FSM state encoding of the
// initiator and the default geometry shared with the memory model.
//   DEF_ADDR_W    address width (word address)
//   DEF_DATA_W    data word width
//   DEF_MEM_DEPTH number of implemented memory words
package data_mem_pkg;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_MEM_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_master.sv
// Module: data_mem_master
// Initiator side of the 16-bit data-memory port. Accepts one load/store
// request over a valid/ready handshake, drives the memory strobes for one
// full cycle (the memory samples on the mid-cycle negedge), captures the
// memory read data at the end of that cycle and returns it over a second
// valid/ready handshake. All outputs are registered.
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   Req_Valid/Req_Ready             request handshake
//   Req_Write, Req_Addr, Req_Wdata  request payload (1 = store)
//   Rsp_Valid/Rsp_Ready             response handshake
//   Rsp_Rdata, Rsp_Err              response payload (word read back, error)
//   Mem_Addr, Mem_Read, Mem_Write,
//   Mem_Data_In, Mem_Data_Out       data-memory interface
//   Txn_Count                       completed responses, wraps at 16 bits
// Configuration macro: DATA_MEM_BOUNDS_CHECK_EN -- when defined, requests with
// Req_Addr >= MEM_DEPTH leave the memory untouched and respond with
// Rsp_Err=1, Rsp_Rdata=0. When undefined, Rsp_Err is constant 0.
module data_mem_master
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_Wdata,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_Rdata,
  output logic              Rsp_Err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [DATA_W-1:0] Mem_Data_In,
  input  logic [DATA_W-1:0] Mem_Data_Out,
  output logic [15:0]       Txn_Count
);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t            state, state_d;
  logic              oob_q, oob_d;
  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_read_d;
  logic              mem_write_d;
  logic [DATA_W-1:0] mem_data_in_d;
  logic [15:0]       txn_count_d;
  logic              req_oob;

  // With the check disabled BOUNDS_EN folds this to a constant 0.
  assign req_oob = BOUNDS_EN && (32'(Req_Addr) >= MEM_DEPTH);

  always_comb begin
    state_d       = state;
    oob_d         = oob_q;
    req_ready_d   = Req_Ready;
    rsp_valid_d   = Rsp_Valid;
    rsp_rdata_d   = Rsp_Rdata;
    rsp_err_d     = Rsp_Err;
    mem_addr_d    = Mem_Addr;
    mem_data_in_d = Mem_Data_In;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    txn_count_d   = Txn_Count;

    unique case (state)
      ST_IDLE: begin
        if (Req_Valid) begin
          // Strobes are loaded on the accepting edge so they are stable for
          // the whole ACCESS cycle, including the memory's negedge.
          state_d       = ST_ACCESS;
          req_ready_d   = 1'b0;
          oob_d         = req_oob;
          mem_addr_d    = Req_Addr;
          mem_data_in_d = Req_Wdata;
          mem_write_d   = Req_Write & ~req_oob;
          mem_read_d    = ~Req_Write & ~req_oob;
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = oob_q ? '0 : Mem_Data_Out;
        rsp_err_d   = oob_q;
      end
      ST_RESP: begin
        if (Rsp_Ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          txn_count_d = Txn_Count + 16'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      oob_q       <= 1'b0;
      Req_Ready   <= 1'b1;
      Rsp_Valid   <= 1'b0;
      Rsp_Rdata   <= '0;
      Rsp_Err     <= 1'b0;
      Mem_Addr    <= '0;
      Mem_Read    <= 1'b0;
      Mem_Write   <= 1'b0;
      Mem_Data_In <= '0;
      Txn_Count   <= '0;
    end else begin
      state       <= state_d;
      oob_q       <= oob_d;
      Req_Ready   <= req_ready_d;
      Rsp_Valid   <= rsp_valid_d;
      Rsp_Rdata   <= rsp_rdata_d;
      Rsp_Err     <= rsp_err_d;
      Mem_Addr    <= mem_addr_d;
      Mem_Read    <= mem_read_d;
      Mem_Write   <= mem_write_d;
      Mem_Data_In <= mem_data_in_d;
      Txn_Count   <= txn_count_d;
    end
  end

endmodule
